pipe_stage_skid: RTL and testbench

Parametrised pipeline-stage register with a valid/ready handshake, an optional two-entry skid buffer, flush (bubble insertion) and a saturating drop counter. It is the next-generation replacement for the fixed-field inter-stage latches between IF/ID/EXE/MEM/WB. Each control and data bundle is packed into two buses. Back-pressure is supported without a combinational ready path when SKID=1.

---
 rtl/pipe_stage_skid.sv | 105 ++++++++++
 tb/tb_pipe_stage_skid.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, an optional two-entry skid buffer,
// flush-driven bubble insertion and a saturating count of the beats a flush kills.
module pipe_stage_skid #(
   parameter int DATA_W      = 32,
   parameter int CTRL_W      = 8,
   parameter int SKID        = 1,
   parameter int BUBBLE_ZERO = 1,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   input  logic              flush,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  drop_cnt,
   input  logic              drop_clr
);

   logic              m_valid, s_valid;
   logic [CTRL_W-1:0] m_ctrl, s_ctrl;
   logic [DATA_W-1:0] m_data, s_data;
   logic              accept, deliver;
   logic [2:0]        drop_inc;
   logic [CNT_W+2:0]  drop_sum;

   // With the skid buffer, in_ready comes straight from a flop; s_valid stays 0 otherwise.
   assign in_ready  = (SKID != 0) ? !s_valid : (!m_valid || out_ready);
   assign accept    = in_valid && in_ready;
   assign deliver   = m_valid && out_ready;
   assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

   assign out_valid = m_valid;
   assign out_ctrl  = m_valid ? m_ctrl : '0;
   assign out_data  = (m_valid || (BUBBLE_ZERO == 0)) ? m_data : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid <= 1'b0;
         s_valid <= 1'b0;
         m_ctrl  <= '0;
         m_data  <= '0;
         s_ctrl  <= '0;
         s_data  <= '0;
      end else if (flush) begin
         m_valid <= 1'b0;
         s_valid <= 1'b0;
      end else if (SKID != 0) begin
         if (!m_valid || deliver) begin
            if (s_valid) begin
               m_valid <= 1'b1;
               m_ctrl  <= s_ctrl;
               m_data  <= s_data;
               s_valid <= accept;
               if (accept) begin
                  s_ctrl <= in_ctrl;
                  s_data <= in_data;
               end
            end else if (accept) begin
               m_valid <= 1'b1;
               m_ctrl  <= in_ctrl;
               m_data  <= in_data;
            end else begin
               m_valid <= 1'b0;
            end
         end else if (accept) begin
            s_valid <= 1'b1;
            s_ctrl  <= in_ctrl;
            s_data  <= in_data;
         end
      end else begin
         if (accept) begin
            m_valid <= 1'b1;
            m_ctrl  <= in_ctrl;
            m_data  <= in_data;
         end else if (deliver) begin
            m_valid <= 1'b0;
         end
      end
   end

   // Killed beats = held entries, minus the one leaving downstream, plus the one arriving.
   assign drop_inc = {1'b0, occupancy} + {2'b00, accept} - {2'b00, deliver};
   assign drop_sum = {3'b000, drop_cnt} + {{CNT_W{1'b0}}, drop_inc};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_cnt <= '0;
      end else if (drop_clr) begin
         drop_cnt <= '0;
      end else if (flush) begin
         if (drop_sum > {3'b000, {CNT_W{1'b1}}})
            drop_cnt <= '1;
         else
            drop_cnt <= drop_sum[CNT_W-1:0];
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a scoreboard queue of expected beats checked by a
// negedge monitor, plus direct checks of occupancy, flush counting, gating and reset.
module tb_pipe_stage_skid;

   logic        clk, rst;
   logic        in_valid, out_ready, flush, drop_clr;
   logic [7:0]  in_ctrl;
   logic [31:0] in_data;

   logic        in_ready, out_valid;
   logic [7:0]  out_ctrl;
   logic [31:0] out_data;
   logic [1:0]  occupancy;
   logic [15:0] drop_cnt;

   logic        b_in_ready, b_out_valid;
   logic [7:0]  b_out_ctrl;
   logic [31:0] b_out_data;
   logic [1:0]  b_occupancy;
   logic [1:0]  b_drop_cnt;

   int errors = 0;
   int checks = 0;
   logic [39:0] exp_q[$];

   pipe_stage_skid #(.DATA_W(32), .CTRL_W(8), .SKID(1), .BUBBLE_ZERO(1), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
      .out_data(out_data), .flush(flush), .occupancy(occupancy), .drop_cnt(drop_cnt),
      .drop_clr(drop_clr));

   pipe_stage_skid #(.DATA_W(32), .CTRL_W(8), .SKID(1), .BUBBLE_ZERO(0), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_ctrl(in_ctrl),
      .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready), .out_ctrl(b_out_ctrl),
      .out_data(b_out_data), .flush(flush), .occupancy(b_occupancy), .drop_cnt(b_drop_cnt),
      .drop_clr(drop_clr));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [7:0] c, input logic [31:0] d, input bit keep);
      in_valid = 1'b1;
      in_ctrl  = c;
      in_data  = d;
      if (keep) exp_q.push_back({c, d});
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_ctrl  = '0;
      in_data  = '0;
   endtask

   task automatic fill_two();
      out_ready = 1'b0;
      beat(8'h4d, 32'h40, 1'b0);
      tick();
      beat(8'h5e, 32'h50, 1'b0);
      tick();
      idle();
   endtask

   // Monitor: every delivery must match the head of the expected queue; also checks the
   // upstream hold rule while the stage is stalling us.
   logic        prv_stall;
   logic [7:0]  prv_c;
   logic [31:0] prv_d;
   initial prv_stall = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         prv_stall = 1'b0;
      end else begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 64'(out_data), 64'hffff_ffff_ffff_ffff);
            end else begin
               logic [39:0] e;
               e = exp_q.pop_front();
               chk("sb_ctrl", 64'(out_ctrl), 64'(e[39:32]));
               chk("sb_data", 64'(out_data), 64'(e[31:0]));
            end
         end
         if (prv_stall)
            chk("hold_rule", 64'({in_valid, in_ctrl, in_data}), 64'({1'b1, prv_c, prv_d}));
         prv_stall = in_valid && !in_ready;
         prv_c     = in_ctrl;
         prv_d     = in_data;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      out_ready = 1'b0;
      flush = 1'b0;
      drop_clr = 1'b0;
      idle();
      #2;
      chk("rst_out_valid", 64'(out_valid), 0);
      chk("rst_in_ready", 64'(in_ready), 1);
      chk("rst_occ", 64'(occupancy), 0);
      chk("rst_drop", 64'(drop_cnt), 0);
      chk("rst_out_data", 64'(out_data), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // streaming
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         beat(8'(i), 32'(i), 1'b1);
         chk("stream_in_ready", 64'(in_ready), 1);
         tick();
         chk("stream_occ", 64'(occupancy), 1);
         chk("stream_latency", 64'(out_data), 64'(i));
      end
      idle();
      tick();
      chk("stream_drain_occ", 64'(occupancy), 0);

      // stall and skid
      beat(8'h1a, 32'h10, 1'b1);
      tick();
      out_ready = 1'b0;
      beat(8'h2b, 32'h20, 1'b1);
      tick();
      beat(8'h3c, 32'h30, 1'b1);
      for (int i = 0; i < 3; i++) begin
         chk("stall_occ", 64'(occupancy), 2);
         chk("stall_in_ready", 64'(in_ready), 0);
         chk("stall_out_data", 64'(out_data), 'h10);
         tick();
      end
      out_ready = 1'b1;
      tick();
      chk("release_occ", 64'(occupancy), 1);
      chk("release_in_ready", 64'(in_ready), 1);
      chk("release_data_b", 64'(out_data), 'h20);
      tick();
      chk("release_data_c", 64'(out_data), 'h30);
      idle();
      tick();
      chk("release_drain", 64'(occupancy), 0);

      // flush counting and saturation (dut_b has a 2-bit counter)
      fill_two();
      chk("pre_flush_occ", 64'(occupancy), 2);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_out_valid", 64'(out_valid), 0);
      chk("flush_out_ctrl", 64'(out_ctrl), 0);
      chk("flush_occ", 64'(occupancy), 0);
      chk("flush_drop", 64'(drop_cnt), 2);
      chk("flush_drop_b", 64'(b_drop_cnt), 2);
      fill_two();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush2_drop", 64'(drop_cnt), 4);
      chk("sat_drop_b", 64'(b_drop_cnt), 3);

      // flush with simultaneous deliver and accept
      out_ready = 1'b1;
      beat(8'h6f, 32'h60, 1'b1);
      tick();
      chk("ft_occ", 64'(occupancy), 1);
      beat(8'h7a, 32'h70, 1'b0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      idle();
      chk("ft_occ_after", 64'(occupancy), 0);
      chk("ft_out_valid", 64'(out_valid), 0);
      chk("ft_drop", 64'(drop_cnt), 5);
      chk("ft_drop_b", 64'(b_drop_cnt), 3);

      // flush together with drop_clr
      out_ready = 1'b0;
      beat(8'h8b, 32'h80, 1'b0);
      tick();
      idle();
      flush = 1'b1;
      drop_clr = 1'b1;
      tick();
      flush = 1'b0;
      drop_clr = 1'b0;
      chk("clr_drop", 64'(drop_cnt), 0);
      chk("clr_drop_b", 64'(b_drop_cnt), 0);
      chk("clr_occ", 64'(occupancy), 0);

      // bubble gating
      out_ready = 1'b1;
      beat(8'hff, 32'hdead_beef, 1'b1);
      tick();
      chk("bub_ctrl_valid", 64'(out_ctrl), 'hff);
      chk("bub_data_valid_b", 64'(b_out_data), 'hdeadbeef);
      idle();
      tick();
      chk("bub_out_valid", 64'(out_valid), 0);
      chk("bub_out_ctrl", 64'(out_ctrl), 0);
      chk("bub_out_data_zero", 64'(out_data), 0);
      chk("bub_out_valid_b", 64'(b_out_valid), 0);
      chk("bub_out_ctrl_b", 64'(b_out_ctrl), 0);
      chk("bub_out_data_hold", 64'(b_out_data), 'hdeadbeef);

      // reset mid-stall
      fill_two();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("pre_rst_drop", 64'(drop_cnt), 2);
      fill_two();
      chk("pre_rst_occ", 64'(occupancy), 2);
      rst = 1'b1;
      #1;
      chk("arst_out_valid", 64'(out_valid), 0);
      chk("arst_out_ctrl", 64'(out_ctrl), 0);
      chk("arst_out_data", 64'(out_data), 0);
      chk("arst_occ", 64'(occupancy), 0);
      chk("arst_in_ready", 64'(in_ready), 1);
      chk("arst_drop", 64'(drop_cnt), 0);
      chk("arst_drop_b", 64'(b_drop_cnt), 0);
      chk("arst_out_data_b", 64'(b_out_data), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      chk("post_rst_out_valid", 64'(out_valid), 0);
      chk("post_rst_drop", 64'(drop_cnt), 0);
      chk("sb_empty", 64'(exp_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
